// File: rtl/ysyx_23060208_dsram_axil_if.sv
// AXI4-Lite load/store channel bundle between the execute stage and the data SRAM.
// wstrb carries the core's size code rather than byte enables.
interface ysyx_23060208_dsram_axil_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [DATA_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060208_dsram_axil.sv
// Word-addressed data SRAM behind an AXI4-Lite slave with independent read/write FSMs,
// each adding a fixed response latency. Lanes are 8 bits wide; DATA_WIDTH is expected to be 32.
module ysyx_23060208_dsram_axil #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LAT     = 2,
  parameter int                    WR_LAT     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060208_dsram_axil_if.slave   bus
);

  localparam int                    IDX_W  = $clog2(DEPTH);
  localparam logic [DATA_WIDTH-1:0] SPAN   = DATA_WIDTH'(DEPTH * 4);
  localparam logic [3:0]            WR_CNT = 4'(WR_LAT);
  localparam logic [3:0]            RD_CNT = 4'(RD_LAT);
  localparam logic [1:0]            OKAY   = 2'b00;
  localparam logic [1:0]            SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_WAIT = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------- write side ----------------
  logic [1:0]            w_state_q, w_state_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            wstrb_q;

  logic [DATA_WIDTH-1:0] w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_inrng;
  logic                  w_size_ok;
  logic                  w_ok;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_data_sh;
  logic                  w_commit;

  assign w_off     = awaddr_q - BASE_ADDR;
  assign w_inrng   = w_off < SPAN;
  assign w_idx     = w_off[IDX_W+1:2];
  // Aligned halves/bytes land in their lanes with the same byte-offset shift a word uses.
  assign w_data_sh = wdata_q << {awaddr_q[1:0], 3'b000};

  always_comb begin
    w_be      = 4'b0000;
    w_size_ok = 1'b0;
    case (wstrb_q)
      3'b100: begin
        w_be      = 4'b1111;
        w_size_ok = (awaddr_q[1:0] == 2'b00);
      end
      3'b010: begin
        w_be      = awaddr_q[1] ? 4'b1100 : 4'b0011;
        w_size_ok = ~awaddr_q[0];
      end
      3'b001: begin
        w_be      = 4'b0001 << awaddr_q[1:0];
        w_size_ok = 1'b1;
      end
      default: begin
        w_be      = 4'b0000;
        w_size_ok = 1'b0;
      end
    endcase
  end

  assign w_ok     = w_inrng && w_size_ok;
  assign w_commit = (w_state_q == W_WAIT) && (w_cnt_q == 4'd0) && w_ok;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (bus.awvalid) w_state_d = W_DATA;
      W_DATA: begin
        if (bus.wvalid) begin
          w_state_d = W_WAIT;
          w_cnt_d   = WR_CNT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 4'd0) begin
          w_state_d = W_RESP;
          bresp_d   = w_ok ? OKAY : SLVERR;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      W_RESP: if (bus.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 3'b000;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      bresp_q   <= bresp_d;
      if (w_state_q == W_IDLE && bus.awvalid) awaddr_q <= bus.awaddr;
      if (w_state_q == W_DATA && bus.wvalid) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
    end
  end

  // Array has no reset; a reset landing on the commit cycle drops the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_data_sh[8*b +: 8];
      end
    end
  end

  assign bus.awready = (w_state_q == W_IDLE);
  assign bus.wready  = (w_state_q == W_DATA);
  assign bus.bvalid  = (w_state_q == W_RESP);
  assign bus.bresp   = bresp_q;

  // ---------------- read side ----------------
  logic [1:0]            r_state_q, r_state_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] araddr_q;

  logic [DATA_WIDTH-1:0] r_off;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_inrng;
  logic [DATA_WIDTH-1:0] r_word;

  assign r_off   = araddr_q - BASE_ADDR;
  assign r_inrng = r_off < SPAN;
  assign r_idx   = r_off[IDX_W+1:2];
  // Sampled before this cycle's commit lands, so a same-cycle write is not visible.
  assign r_word  = mem_q[r_idx];

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          r_state_d = R_WAIT;
          r_cnt_d   = RD_CNT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) begin
          r_state_d = R_RESP;
          rresp_d   = r_inrng ? OKAY : SLVERR;
          rdata_d   = r_inrng ? (r_word >> {araddr_q[1:0], 3'b000}) : '0;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP: if (bus.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      araddr_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      if (r_state_q == R_IDLE && bus.arvalid) araddr_q <= bus.araddr;
    end
  end

  assign bus.arready = (r_state_q == R_IDLE);
  assign bus.rvalid  = (r_state_q == R_RESP);
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_ysyx_23060208_dsram_axil.sv
// Bench for the data SRAM slave: directed corner cases plus random traffic against a byte-level model.
module tb_ysyx_23060208_dsram_axil;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ysyx_23060208_dsram_axil_if #(.DATA_WIDTH(32)) b2 ();
  ysyx_23060208_dsram_axil_if #(.DATA_WIDTH(32)) b0 ();

  ysyx_23060208_dsram_axil #(.RD_LAT(2), .WR_LAT(2)) dut (
    .clk(clk), .rst(rst), .bus(b2)
  );
  ysyx_23060208_dsram_axil #(.RD_LAT(0), .WR_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Byte-level reference memory keyed by offset from the base address.
  logic [7:0] mb [int];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic start_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] strb);
    int n;
    b2.awaddr = addr; b2.awvalid = 1'b1;
    n = 0;
    while (!b2.awready && n < 50) begin tick(); n++; end
    chk("aw_wait", 32'(n < 50), 32'd1);
    tick();
    b2.awvalid = 1'b0;
    b2.wdata = data; b2.wstrb = strb; b2.wvalid = 1'b1;
    n = 0;
    while (!b2.wready && n < 50) begin tick(); n++; end
    chk("w_wait", 32'(n < 50), 32'd1);
    tick();
    b2.wvalid = 1'b0;
  endtask

  task automatic finish_write(output logic [1:0] resp, output int cyc, input int hold);
    cyc = 0;
    while (!b2.bvalid && cyc < 50) begin tick(); cyc++; end
    resp = b2.bresp;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("bhold_valid", 32'(b2.bvalid), 32'd1);
      chk("bhold_resp", 32'(b2.bresp), 32'(resp));
      chk("bhold_awready", 32'(b2.awready), 32'd0);
    end
    b2.bready = 1'b1;
    tick();
    b2.bready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [2:0] strb, input logic [1:0] exp_resp, input int hold);
    logic [1:0] resp;
    int cyc;
    start_write(addr, data, strb);
    finish_write(resp, cyc, hold);
    chk({tag, "_blat"}, 32'(cyc), 32'd3);
    chk({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp, input int hold);
    int n;
    int cyc;
    logic [31:0] data;
    b2.araddr = addr; b2.arvalid = 1'b1;
    n = 0;
    while (!b2.arready && n < 50) begin tick(); n++; end
    chk({tag, "_arwait"}, 32'(n < 50), 32'd1);
    tick();
    b2.arvalid = 1'b0;
    cyc = 0;
    while (!b2.rvalid && cyc < 50) begin tick(); cyc++; end
    data = b2.rdata;
    chk({tag, "_rlat"}, 32'(cyc), 32'd3);
    chk({tag, "_rdata"}, data, exp_data);
    chk({tag, "_rresp"}, 32'(b2.rresp), 32'(exp_resp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("rhold_valid", 32'(b2.rvalid), 32'd1);
      chk("rhold_data", b2.rdata, data);
      chk("rhold_arready", 32'(b2.arready), 32'd0);
    end
    b2.rready = 1'b1;
    tick();
    b2.rready = 1'b0;
  endtask

  function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [31:0] data,
                                            input logic [2:0] strb);
    logic [31:0] off;
    int sz;
    off = addr - 32'h8000_0000;
    sz = (strb == 3'b100) ? 4 : (strb == 3'b010) ? 2 : (strb == 3'b001) ? 1 : 0;
    if (off >= 32'd4096 || sz == 0 || (off % sz) != 0) return 2'b10;
    for (int i = 0; i < sz; i++) mb[int'(off) + i] = data[8*i +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] mdl_read(input logic [31:0] addr);
    logic [31:0] off;
    logic [31:0] w;
    int base;
    off = addr - 32'h8000_0000;
    if (off >= 32'd4096) return {2'b10, 32'h0};
    base = int'(off) & ~3;
    w = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    return {2'b00, w >> (8 * (off % 4))};
  endfunction

  initial begin
    logic [1:0]  er;
    logic [33:0] rr;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
    total = 0;
    bad = 0;
    {b2.awaddr, b2.awvalid, b2.wdata, b2.wstrb, b2.wvalid, b2.bready} = '0;
    {b2.araddr, b2.arvalid, b2.rready} = '0;
    {b0.awaddr, b0.awvalid, b0.wdata, b0.wstrb, b0.wvalid, b0.bready} = '0;
    {b0.araddr, b0.arvalid, b0.rready} = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_awready", 32'(b2.awready), 32'd1);
    chk("rst_arready", 32'(b2.arready), 32'd1);
    chk("rst_wready", 32'(b2.wready), 32'd0);
    chk("rst_bvalid", 32'(b2.bvalid), 32'd0);
    chk("rst_rvalid", 32'(b2.rvalid), 32'd0);
    chk("rst_rdata", b2.rdata, 32'h0);
    chk("rst_bresp", 32'(b2.bresp), 32'd0);
    chk("rst_rresp", 32'(b2.rresp), 32'd0);
    rst = 1'b0;
    tick();

    // Same-cycle commit/sample on the zero-latency instance.
    b0.awaddr = 32'h8000_0020; b0.awvalid = 1'b1; tick();
    b0.awvalid = 1'b0; b0.wdata = 32'h1111_1111; b0.wstrb = 3'b100; b0.wvalid = 1'b1; tick();
    b0.wvalid = 1'b0; tick();
    chk("c0_bvalid", 32'(b0.bvalid), 32'd1);
    chk("c0_bresp", 32'(b0.bresp), 32'd0);
    b0.bready = 1'b1; tick(); b0.bready = 1'b0;
    b0.awvalid = 1'b1; tick();
    b0.awvalid = 1'b0; b0.wdata = 32'h2222_2222; b0.wvalid = 1'b1;
    b0.araddr = 32'h8000_0020; b0.arvalid = 1'b1; tick();
    b0.wvalid = 1'b0; b0.arvalid = 1'b0; tick();
    chk("c1_rvalid", 32'(b0.rvalid), 32'd1);
    chk("c1_bvalid", 32'(b0.bvalid), 32'd1);
    chk("c1_rdata_old", b0.rdata, 32'h1111_1111);
    b0.bready = 1'b1; b0.rready = 1'b1; tick();
    b0.bready = 1'b0; b0.rready = 1'b0;
    b0.arvalid = 1'b1; tick();
    b0.arvalid = 1'b0; tick();
    chk("c2_rvalid", 32'(b0.rvalid), 32'd1);
    chk("c2_rdata_new", b0.rdata, 32'h2222_2222);
    b0.rready = 1'b1; tick(); b0.rready = 1'b0;

    // Directed store/load, lanes, errors and backpressure.
    wr("word", 32'h8000_0010, 32'hDEAD_BEEF, 3'b100, 2'b00, 4);
    rd("word", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 4);
    wr("byte", 32'h8000_0012, 32'h0000_0055, 3'b001, 2'b00, 0);
    wr("half", 32'h8000_0010, 32'h0000_1234, 3'b010, 2'b00, 0);
    rd("lanes", 32'h8000_0010, 32'hDE55_1234, 2'b00, 0);
    rd("shift", 32'h8000_0012, 32'h0000_DE55, 2'b00, 0);
    wr("misal", 32'h8000_0011, 32'hFFFF_FFFF, 3'b100, 2'b10, 0);
    wr("badsz", 32'h8000_0010, 32'hFFFF_FFFF, 3'b011, 2'b10, 0);
    rd("unchg", 32'h8000_0010, 32'hDE55_1234, 2'b00, 0);
    rd("below", 32'h7FFF_FFFC, 32'h0, 2'b10, 0);
    wr("above", 32'h8000_1000, 32'h1, 3'b100, 2'b10, 0);

    // A W beat with no AW pending must not be accepted.
    b2.wdata = 32'hABCD_0000; b2.wstrb = 3'b100; b2.wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_before_aw", 32'(b2.wready), 32'd0);
    end
    b2.wvalid = 1'b0;

    // Reset while the write is still counting down.
    start_write(32'h8000_0010, 32'h9999_9999, 3'b100);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rmid_bvalid", 32'(b2.bvalid), 32'd0);
    chk("rmid_awready", 32'(b2.awready), 32'd1);
    chk("rmid_wready", 32'(b2.wready), 32'd0);
    rd("rmid_old", 32'h8000_0010, 32'hDE55_1234, 2'b00, 0);

    // Random traffic over a small window, with stray out-of-range addresses.
    for (int i = 0; i < 16; i++) begin
      a = 32'h8000_0100 + 32'(4 * i);
      d = $urandom;
      er = mdl_write(a, d, 3'b100);
      wr("init", a, d, 3'b100, er, 0);
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: a = 32'h8000_1000 + 32'($urandom_range(0, 15));
        1: a = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'h8000_0100 + 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0: s = 3'b100;
          1: s = 3'b010;
          2: s = 3'b001;
          default: s = 3'($urandom_range(0, 7));
        endcase
        d = $urandom;
        er = mdl_write(a, d, s);
        wr("rnd_w", a, d, s, er, 0);
      end else begin
        rr = mdl_read(a);
        rd("rnd_r", a, rr[31:0], rr[33:32], 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
